// File: rtl/eth_decap_pkg.sv
// Shared header constants and the TLP FIFO word layout for the 10G receive decapsulator.
// Field values mirror the encapsulator so both ends agree on the 48-byte header.
package eth_decap_pkg;

    localparam logic [15:0] ETH_P_IP       = 16'h0800;
    localparam logic [7:0]  IP4_PROTO_UDP  = 8'd17;
    localparam logic [3:0]  IPVERSION      = 4'd4;
    localparam logic [3:0]  IP4_IHL        = 4'd5;
    localparam int          ETH_HLEN       = 14;
    localparam int          IP4_HLEN       = 20;
    localparam int          UDP_HLEN       = 8;
    localparam logic [2:0]  TCAP_VER       = 3'b001;
    localparam int          TCAP_HDR_BEATS = 6;

    typedef struct packed {
        logic [7:0]  keep;
        logic [63:0] data;
        logic        last;
        logic        user;
    } tlp_fifo_word_t;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_DATA,
        RX_DROP
    } rx_state_e;

    // Byte k of a beat, byte 0 being first on the wire.
    function automatic logic [7:0] get_byte(input logic [63:0] d, input int k);
        return d[8*k +: 8];
    endfunction

endpackage

// File: rtl/eth_decap_ipcsum.sv
// Streaming IPv4 header checksum over header beats 1-4; verdict valid combinationally on beat 4.
// Latency: accumulates per accepted beat, result same cycle as beat 4.
// Backpressure: none of its own; advances only on beats the parser accepts.
module eth_decap_ipcsum (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        beat_acc,
    input  logic [2:0]  beat_idx,
    input  logic [63:0] tdata,
    output logic        csum_bad
);

    logic [19:0] acc_q;
    logic [19:0] total;
    logic [17:0] beat_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] w0, w1, w2, w3;

    // Big-endian 16-bit words: the even byte is the high half.
    assign w0 = {tdata[7:0],   tdata[15:8]};
    assign w1 = {tdata[23:16], tdata[31:24]};
    assign w2 = {tdata[39:32], tdata[47:40]};
    assign w3 = {tdata[55:48], tdata[63:56]};

    always_comb begin
        beat_sum = '0;
        case (beat_idx)
            3'd1:       beat_sum = {2'b00, w3};
            3'd2, 3'd3: beat_sum = {2'b00, w0} + {2'b00, w1} + {2'b00, w2} + {2'b00, w3};
            3'd4:       beat_sum = {2'b00, w0};
            default:    ;
        endcase
    end

    assign total    = acc_q + {2'b00, beat_sum};
    assign fold1    = {1'b0, total[15:0]} + {13'b0, total[19:16]};
    assign fold2    = fold1[15:0] + {15'b0, fold1[16]};
    assign csum_bad = (beat_idx == 3'd4) && (fold2 != 16'hFFFF);

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            acc_q <= '0;
        end else if (beat_acc) begin
            acc_q <= (beat_idx == 3'd0) ? '0 : total;
        end
    end

endmodule

// File: rtl/eth_decap.sv
// Strips the 48 B Eth/IPv4/UDP/TCAP header and writes TLP payload beats to the TLP FIFO.
// Latency: zero; payload beats reach wr_en/din in the cycle they are accepted.
// Backpressure: tready follows !full while forwarding payload; header/drop beats always accepted. Optional RX_IPCHECK_EN.
module eth_decap
    import eth_decap_pkg::*;
#(
    parameter logic [31:0] ip_daddr  = {8'd192, 8'd168, 8'd11, 8'd1},
    parameter logic [15:0] udp_dport = 16'h3776,
    parameter logic [2:0]  tcap_ver  = 3'b001,
    parameter int          hdr_beats = TCAP_HDR_BEATS
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    output logic [39:0] tcap_ts,
    output logic        tcap_dir,
    output logic [31:0] rx_pkts,
    output logic [31:0] rx_drops
);

    rx_state_e      state_q, state_d;
    logic [2:0]     beat_cnt;
    logic           err_q;
    logic           beat_acc;
    logic           hdr_acc;
    logic           hdr_last_beat;
    logic           beat_fail;
    logic           hdr_bad;
    logic           csum_bad;
    tlp_fifo_word_t fifo_word;

    assign s_axis_tready = (state_q == RX_DATA) ? !full : 1'b1;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign hdr_acc       = beat_acc && (state_q == RX_HDR);
    assign hdr_last_beat = (beat_cnt == 3'(hdr_beats - 1));
    assign hdr_bad       = err_q || beat_fail;
    assign fifo_word     = '{keep: s_axis_tkeep, data: s_axis_tdata,
                             last: s_axis_tlast, user: s_axis_tuser};

`ifdef RX_IPCHECK_EN
    eth_decap_ipcsum u_ipcsum (
        .clk156   (clk156),
        .sys_rst  (sys_rst),
        .beat_acc (hdr_acc),
        .beat_idx (beat_cnt),
        .tdata    (s_axis_tdata),
        .csum_bad (csum_bad)
    );
`else
    assign csum_bad = 1'b0;
`endif

    // Each header field is checked on the beat that carries it.
    always_comb begin
        beat_fail = (s_axis_tkeep != 8'hFF);
        case (beat_cnt)
            3'd1: begin
                if ({get_byte(s_axis_tdata, 4), get_byte(s_axis_tdata, 5)} != ETH_P_IP ||
                    get_byte(s_axis_tdata, 6) != {IPVERSION, IP4_IHL})
                    beat_fail = 1'b1;
            end
            3'd2: begin
                if (get_byte(s_axis_tdata, 7) != IP4_PROTO_UDP)
                    beat_fail = 1'b1;
            end
            3'd3: begin
                if ({get_byte(s_axis_tdata, 6), get_byte(s_axis_tdata, 7)} != ip_daddr[31:16])
                    beat_fail = 1'b1;
            end
            3'd4: begin
                if ({get_byte(s_axis_tdata, 0), get_byte(s_axis_tdata, 1)} != ip_daddr[15:0] ||
                    {get_byte(s_axis_tdata, 4), get_byte(s_axis_tdata, 5)} != udp_dport ||
                    csum_bad)
                    beat_fail = 1'b1;
            end
            3'd5: begin
                if (s_axis_tdata[23:21] != tcap_ver)
                    beat_fail = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        din     = '0;
        case (state_q)
            RX_HDR: begin
                if (beat_acc && !s_axis_tlast && hdr_last_beat)
                    state_d = hdr_bad ? RX_DROP : RX_DATA;
            end
            RX_DATA: begin
                wr_en = s_axis_tvalid && !full;
                if (wr_en)
                    din = fifo_word;
                if (beat_acc && s_axis_tlast)
                    state_d = RX_HDR;
            end
            RX_DROP: begin
                if (beat_acc && s_axis_tlast)
                    state_d = RX_HDR;
            end
            default: state_d = RX_HDR;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q  <= RX_HDR;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            tcap_ts  <= '0;
            tcap_dir <= 1'b0;
            rx_pkts  <= '0;
            rx_drops <= '0;
        end else begin
            state_q <= state_d;
            if (hdr_acc) begin
                if (s_axis_tlast || hdr_last_beat) begin
                    beat_cnt <= '0;
                    err_q    <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + 3'd1;
                    err_q    <= hdr_bad;
                end
                // Runts end inside the header; a good header publishes its TCAP fields.
                if (s_axis_tlast) begin
                    rx_drops <= rx_drops + 32'd1;
                end else if (hdr_last_beat && !hdr_bad) begin
                    tcap_ts  <= {s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40],
                                 s_axis_tdata[55:48], s_axis_tdata[63:56]};
                    tcap_dir <= s_axis_tdata[20];
                end
            end
            if (state_q == RX_DATA && beat_acc && s_axis_tlast)
                rx_pkts <= rx_pkts + 32'd1;
            if (state_q == RX_DROP && beat_acc && s_axis_tlast)
                rx_drops <= rx_drops + 32'd1;
        end
    end

endmodule

// File: tb/tb_eth_decap.sv
// Directed frames into eth_decap; expected FIFO words are queued by the driver and
// popped by an independent write monitor, counters and TCAP fields checked after each frame.
module tb_eth_decap;

    logic        clk156 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        wr_en;
    logic [73:0] din;
    logic        full = 1'b0;
    logic [39:0] tcap_ts;
    logic        tcap_dir;
    logic [31:0] rx_pkts;
    logic [31:0] rx_drops;

    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cycles = 0;
    logic [73:0] exp_q[$];
    logic [7:0]  hb[48];

    always #3 clk156 = ~clk156;

    eth_decap dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .wr_en         (wr_en),
        .din           (din),
        .full          (full),
        .tcap_ts       (tcap_ts),
        .tcap_dir      (tcap_dir),
        .rx_pkts       (rx_pkts),
        .rx_drops      (rx_drops)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest queued expectation.
    always @(negedge clk156) begin
        if (!sys_rst && wr_en) begin
            logic [73:0] w;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write actual din=%0h required no write", din);
            end else begin
                w = exp_q.pop_front();
                if (din !== w) begin
                    n_fail++;
                    $display("FAIL fifo_word actual=%0h required=%0h", din, w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic make_hdr(input logic [31:0] daddr, input bit bad_csum);
        logic [383:0] base;
        int unsigned  s;
        logic [15:0]  c;
        base = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h08, 8'h00,
                8'h45, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
                8'hc0, 8'ha8, 8'h0b, 8'h02, 8'hc0, 8'ha8, 8'h0b, 8'h01,
                8'h12, 8'h34, 8'h37, 8'h76, 8'h00, 8'h2e, 8'h00, 8'h00,
                8'h30, 8'haa, 8'haa, 8'haa, 8'haa, 8'haa};
        for (int i = 0; i < 48; i++) hb[i] = base[383-8*i -: 8];
        hb[30] = daddr[31:24]; hb[31] = daddr[23:16]; hb[32] = daddr[15:8]; hb[33] = daddr[7:0];
        s = 0;
        for (int i = 14; i < 34; i += 2) s += 32'({hb[i], hb[i+1]});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        c = ~s[15:0];
        if (bad_csum) c = 16'h0000;
        hb[24] = c[15:8];
        hb[25] = c[7:0];
    endtask

    function automatic logic [63:0] hdr_beat(input int b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = hb[8*b+k];
        return r;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last, input bit user);
        bit acc;
        int budget;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tuser = user;
        s_axis_tvalid = 1'b1;
        budget = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk156);
            acc = s_axis_tready;
            if (!acc) stall_cycles++;
            @(posedge clk156);
            #1;
            budget++;
            if (!acc && budget > 100) begin
                n_checks++; n_fail++;
                $display("FAIL beat_accept_timeout actual=not accepted required=accepted");
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (n) @(posedge clk156);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] daddr, input bit bad_csum, input logic [7:0] last_keep,
                              input bit last_user, input bit expect_ok, input bit stall,
                              input bit gap, input int tag);
        logic [63:0] d;
        logic [7:0]  k;
        make_hdr(daddr, bad_csum);
        for (int b = 0; b < 6; b++) begin
            send_beat(hdr_beat(b), 8'hFF, 1'b0, 1'b0);
            if (gap && b == 2) idle(1);
        end
        for (int p = 0; p < 4; p++) begin
            d = {32'hC0FFEE00, tag[15:0], 16'(p)};
            k = (p == 3) ? last_keep : 8'hFF;
            if (expect_ok) exp_q.push_back({k, d, p == 3, (p == 3) && last_user});
            if (gap && p == 2) idle(1);
            if (stall && p == 1) begin
                full = 1'b1;
                fork
                    send_beat(d, k, p == 3, (p == 3) && last_user);
                    begin
                        repeat (5) begin
                            @(negedge clk156);
                            check("stall_tready", 80'(s_axis_tready), 80'(0));
                        end
                        @(posedge clk156);
                        #1 full = 1'b0;
                    end
                join
            end else begin
                send_beat(d, k, p == 3, (p == 3) && last_user);
            end
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        full = 1'b0;
        repeat (2) @(posedge clk156);
        #1 sys_rst = 1'b0;
        exp_q.delete();
    endtask

    localparam logic [31:0] GOOD_DADDR = 32'hC0A80B01;
    localparam logic [31:0] BAD_DADDR  = 32'hC0A80B09;

    initial begin
        do_reset();
        @(negedge clk156);
        check("rst_rx_pkts",  80'(rx_pkts),  80'(0));
        check("rst_rx_drops", 80'(rx_drops), 80'(0));
        check("rst_tcap_ts",  80'(tcap_ts),  80'(0));
        check("rst_tcap_dir", 80'(tcap_dir), 80'(0));
        check("rst_wr_en",    80'(wr_en),    80'(0));
        check("rst_din",      80'(din),      80'(0));
        check("rst_tready",   80'(s_axis_tready), 80'(1));
        @(posedge clk156); #1;

        // Valid 80 B frame with idle gaps inside header and payload.
        send_frame(GOOD_DADDR, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        idle(2);
        check("t1_rx_pkts",  80'(rx_pkts),  80'(1));
        check("t1_rx_drops", 80'(rx_drops), 80'(0));
        check("t1_tcap_ts",  80'(tcap_ts),  80'(40'haaaaaaaaaa));
        check("t1_tcap_dir", 80'(tcap_dir), 80'(1));
        check("t1_queue_drained", 80'(exp_q.size()), 80'(0));

        // Wrong IP destination: whole frame dropped, never stalled.
        do_reset();
        stall_cycles = 0;
        send_frame(BAD_DADDR, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        idle(2);
        check("t2_stalls",   80'(stall_cycles), 80'(0));
        check("t2_rx_drops", 80'(rx_drops), 80'(1));
        check("t2_rx_pkts",  80'(rx_pkts),  80'(0));
        check("t2_tcap_ts",  80'(tcap_ts),  80'(0));

        // FIFO full for 5 cycles on payload beat 2.
        do_reset();
        send_frame(GOOD_DADDR, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        idle(2);
        check("t3_rx_pkts", 80'(rx_pkts), 80'(1));
        check("t3_queue_drained", 80'(exp_q.size()), 80'(0));

        // 40 B runt ending on header beat 4, then a good frame.
        do_reset();
        make_hdr(GOOD_DADDR, 1'b0);
        for (int b = 0; b < 5; b++) send_beat(hdr_beat(b), 8'hFF, b == 4, 1'b0);
        idle(1);
        check("t4_runt_drops", 80'(rx_drops), 80'(1));
        check("t4_runt_pkts",  80'(rx_pkts),  80'(0));
        send_frame(GOOD_DADDR, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        idle(2);
        check("t4_rx_pkts",  80'(rx_pkts),  80'(1));
        check("t4_rx_drops", 80'(rx_drops), 80'(1));

        // Back-to-back frames, partial last beat, second one flagged by the MAC.
        do_reset();
        send_frame(GOOD_DADDR, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        send_frame(GOOD_DADDR, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        idle(2);
        check("t5_rx_pkts",  80'(rx_pkts),  80'(2));
        check("t5_rx_drops", 80'(rx_drops), 80'(0));
        check("t5_queue_drained", 80'(exp_q.size()), 80'(0));

        // Zeroed IP checksum: only rejected when checksum checking is built in.
        do_reset();
`ifdef RX_IPCHECK_EN
        send_frame(GOOD_DADDR, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 7);
        idle(2);
        check("t6_rx_drops", 80'(rx_drops), 80'(1));
        check("t6_rx_pkts",  80'(rx_pkts),  80'(0));
`else
        send_frame(GOOD_DADDR, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 7);
        idle(2);
        check("t6_rx_drops", 80'(rx_drops), 80'(0));
        check("t6_rx_pkts",  80'(rx_pkts),  80'(1));
`endif
        check("t6_queue_drained", 80'(exp_q.size()), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_decap.md
Name: eth_decap

Overview:
- Receive-side counterpart of the Eth+IP+UDP+TCAP encapsulator on the 10G path (clk156 domain).
- Accepts 64-bit AXI-Stream frames from the MAC RX and checks the fixed 48-byte header (6 beats).
- Strips the header and writes the TLP payload beats into the TLP FIFO, using the same 74-bit word format the encapsulator reads.
- Non-matching or malformed frames are dropped whole and counted.

Parameters:
- ip_daddr, {8'd192,8'd168,8'd11,8'd1}: local IPv4 address; frame IP daddr must equal it.
- udp_dport, 16'h3776: required UDP destination port.
- tcap_ver, 3'b001: required TCAP header version.
- hdr_beats, 6: header length in 64-bit beats (48 B); fixed by packet layout, not for override.

Ports:
- clk156  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- s_axis_tvalid  in  1  RX frame beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tdata  in  64  byte k of beat at [8k+7:8k], network order.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  MAC error flag, sampled on last beat.
- wr_en  out  1  FIFO write strobe.
- din  out  74  {tkeep[7:0], tdata[63:0], tlast, tuser} → din[73:66], [65:2], [1], [0].
- full  in  1  FIFO full.
- tcap_ts  out  40  timestamp of last accepted frame.
- tcap_dir  out  1  dir bit of last accepted frame.
- rx_pkts  out  32  accepted frame counter.
- rx_drops  out  32  dropped frame counter.

Behaviour:
- Reset: state RX_HDR, beat count 0, sticky error flag clear, wr_en=0, din=0, tcap_ts=0, tcap_dir=0, rx_pkts=0, rx_drops=0.
- s_axis_tready = 1 in RX_HDR and RX_DROP; = !full in RX_DATA.
- RX_HDR:
  - Counts accepted beats 0..5.
  - Checks each field on its beat and ORs failures into the sticky error flag:
    - beat1: bytes4-5 == 16'h0800; byte6 == 8'h45.
    - beat2: byte7 == 8'd17.
    - beat3/4: daddr (beat3 bytes6-7, beat4 bytes0-1) == ip_daddr.
    - beat4: bytes4-5 == udp_dport.
    - beat5: byte2[7:5] == tcap_ver.
  - tkeep != 8'hFF on any header beat is also a failure.
  - Latches dir (byte2[4]) and ts (beat5 bytes3-7, MSB first) into shadow registers.
- Transitions from RX_HDR:
  - tlast on beats 0..5 (runt, including header-only frame): drop, rx_drops+1, stay in RX_HDR, count := 0.
  - Beat 5 accepted, no tlast, error flag set (including a beat-5 failure): → RX_DROP.
  - Beat 5 accepted, no tlast, no error: → RX_DATA; copy shadow to tcap_ts/tcap_dir.
- RX_DATA:
  - Each accepted beat: wr_en=1 same cycle; din = {tkeep, tdata unmodified, tlast, tuser}. Combinational, zero latency.
  - On tlast: rx_pkts+1 (including tuser=1 frames; tuser is passed through for downstream discard), → RX_HDR.
  - full stalls via tready; no beat is lost or duplicated.
- RX_DROP: consume beats with no writes; on tlast: rx_drops+1, → RX_HDR.
- tvalid low mid-frame: hold state, no write.
- Counters are 32-bit and wrap silently.
- sys_rst mid-frame: immediate return to reset state. Remaining beats of that frame are parsed as a new header and dropped as a runt or mismatch. Partial FIFO contents are not cleaned here.

Optional Feature:
- RX_IPCHECK_EN defined:
  - Accumulate 10 IP header 16-bit words (beats 1-4) into a 20-bit sum.
  - Fold carries twice at beat 4; result must equal 16'hFFFF, else set the error flag.
- Not defined: IP checksum ignored; no adder logic.

Decomposition:
- ethernet_pkg/ip_pkg/udp_pkg/pcie_tcap_pkg: reuse ETH_P_IP, IP4_PROTO_UDP, IPVERSION, header lengths.
- Add to pcie_tcap_pkg: TCAP_VER, TCAP_HDR_BEATS=6, typedef tlp_fifo_word_t (74-bit struct keep/data/last/user).
- Sub-module eth_decap_ipcsum: streaming checksum accumulator, instantiated only under RX_IPCHECK_EN.

Test Plan:
- Valid 80 B frame (6 hdr + 4 payload beats, last tkeep 8'hFF), full=0 → 4 consecutive wr_en; din[65:2] equals payload; din[1]=1 on 4th; rx_pkts=1; tcap_ts=40'haaaaaaaaaa.
- Same frame with daddr 192.168.11.9 → no wr_en; rx_drops=1; tready held 1 throughout.
- Payload with full asserted on payload beat 2 for 5 cycles → tready=0 those cycles; exactly 4 writes, order preserved.
- 40 B runt, tlast on beat 4 → rx_drops=1; next valid frame accepted (rx_pkts=1).
- Back-to-back valid frames, tvalid continuous, last payload tkeep 8'h0F → 2×N writes, din[73:66]=8'h0F on each last beat, rx_pkts=2.
- RX_IPCHECK_EN: corrupt checksum to 16'h0000 → dropped, rx_drops=1; without the macro the same frame is accepted.
